// File: rtl/uart_pkg.sv
// Shared UART constants, divisor type and the reset-divisor helper.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE_DEF = 16;
    localparam int unsigned UART_BAUD_DEF       = 9600;
    localparam int unsigned UART_DIV_W_DEF      = 16;
    localparam int unsigned UART_FRAC_W_DEF     = 4;

    typedef struct packed {
        logic [UART_DIV_W_DEF-1:0]  div_int;
        logic [UART_FRAC_W_DEF-1:0] div_frac;
    } baud_div_t;

    // Fixed-point clocks-per-os_tick, rounded to nearest, FRAC_W fractional bits.
    function automatic logic [63:0] calc_baud_divx(
        input logic [63:0] clk_freq,
        input logic [63:0] baud,
        input logic [63:0] os,
        input logic [63:0] frac_w
    );
        logic [63:0] den;
        den = baud * os;
        return ((clk_freq << frac_w) + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/baud_frac_counter.sv
// Interval down-counter with fractional accumulator; pulses tick_o on the
// last enabled cycle of each div_int(+carry) interval.
module baud_frac_counter #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              tick_o
);

    logic [DIV_W:0]  cnt_q, cnt_d;
    logic [DIV_W:0]  remain;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0] acc_sum;

    // cnt_q == 0 means a fresh interval: its length is loaded from the
    // divisor and accumulator carry that are current at that moment.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, div_frac_i};
        remain  = (cnt_q == '0)
                ? ({1'b0, div_int_i} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]})
                : cnt_q;
        tick_o  = en_i && !clr_i && (remain == (DIV_W+1)'(1));
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (clr_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
                acc_d = acc_sum[FRAC_W-1:0];
            end else begin
                cnt_d = remain - (DIV_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud tick generator: divisor staging/handshake, oversample
// phase, bit tick and config error around baud_frac_counter.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned DEFAULT_BAUD = UART_BAUD_DEF,
    parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE_DEF,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          en,
    input  logic                          restart,
    input  logic [DIV_W-1:0]              cfg_div_int,
    input  logic [FRAC_W-1:0]             cfg_div_frac,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    output logic                          cfg_err,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);
    localparam logic [63:0] DEFX = calc_baud_divx(64'(CLK_FREQ), 64'(DEFAULT_BAUD),
                                                  64'(OVERSAMPLE), 64'(FRAC_W));
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEFX >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFX);

    logic [DIV_W-1:0]  act_int_q, act_int_d, stg_int_q, stg_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d, stg_frac_q, stg_frac_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              os_q, os_d, bit_q, bit_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              boundary, xfer, bad, good;

    baud_frac_counter #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_cnt (
        .clk        (clk),
        .arst_n     (arst_n),
        .en_i       (en),
        .clr_i      (restart),
        .div_int_i  (act_int_q),
        .div_frac_i (act_frac_q),
        .tick_o     (boundary)
    );

    assign cfg_ready = !pend_q;
    assign cfg_err   = err_q;
    assign os_tick   = os_q;
    assign bit_tick  = bit_q;
    assign os_phase  = phase_q;

    always_comb begin
        xfer       = cfg_valid && cfg_ready;
        bad        = xfer && (cfg_div_int < DIV_W'(2));
        good       = xfer && !bad;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        stg_int_d  = stg_int_q;
        stg_frac_d = stg_frac_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        err_d      = bad;
        os_d       = boundary;
        bit_d      = boundary && (phase_q == PH_W'(OVERSAMPLE - 1));
        // A transfer can only happen while nothing is pending, so restart
        // activates either the fresh offer or the staged value, never both.
        if (restart) begin
            phase_d = '0;
            pend_d  = 1'b0;
            if (good) begin
                act_int_d  = cfg_div_int;
                act_frac_d = cfg_div_frac;
            end else if (pend_q) begin
                act_int_d  = stg_int_q;
                act_frac_d = stg_frac_q;
            end
        end else begin
            if (boundary) begin
                phase_d = phase_q + PH_W'(1);
                if (pend_q) begin
                    act_int_d  = stg_int_q;
                    act_frac_d = stg_frac_q;
                    pend_d     = 1'b0;
                end
            end
            if (good) begin
                stg_int_d  = cfg_div_int;
                stg_frac_d = cfg_div_frac;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            act_int_q  <= DEF_INT;
            act_frac_q <= DEF_FRAC;
            stg_int_q  <= '0;
            stg_frac_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            os_q       <= 1'b0;
            bit_q      <= 1'b0;
            phase_q    <= '0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            stg_int_q  <= stg_int_d;
            stg_frac_q <= stg_frac_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            os_q       <= os_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: cycle reference model plus directed interval checks.
module tb_uart_baud_gen_frac;

    localparam int OS   = 16;
    localparam int FMOD = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        en = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] cfg_div_int = '0;
    logic [3:0]  cfg_div_frac = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, cfg_err, os_tick, bit_tick;
    logic [3:0]  os_phase;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int os_q[$];
    int bit_q[$];

    int m_int, m_frac, m_sint, m_sfrac, m_acc, m_done, m_phase;
    bit m_pend, e_os, e_bit, e_err;

    uart_baud_gen_frac dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .en           (en),
        .restart      (restart),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .os_tick      (os_tick),
        .bit_tick     (bit_tick),
        .os_phase     (os_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic m_reset();
        m_int = 651; m_frac = 1; m_sint = 0; m_sfrac = 0;
        m_acc = 0; m_done = 0; m_phase = 0; m_pend = 0;
        e_os = 0; e_bit = 0; e_err = 0;
    endtask

    task automatic chk_outputs();
        chk("os_tick",   os_tick,   e_os);
        chk("bit_tick",  bit_tick,  e_bit);
        chk("os_phase",  os_phase,  m_phase);
        chk("cfg_ready", cfg_ready, !m_pend);
        chk("cfg_err",   cfg_err,   e_err);
    endtask

    // One clock: drive inputs, advance the model by the spec's rules, then compare.
    task automatic cyc(input bit e, input bit rs, input bit v, input int di, input int df);
        int len;
        bit xfer, bad;
        en = e; restart = rs; cfg_valid = v;
        cfg_div_int = 16'(di); cfg_div_frac = 4'(df);
        len  = m_int + (((m_acc + m_frac) >= FMOD) ? 1 : 0);
        xfer = v && !m_pend;
        bad  = xfer && (di < 2);
        e_err = bad; e_os = 0; e_bit = 0;
        if (rs) begin
            m_done = 0; m_acc = 0; m_phase = 0;
            if (xfer && !bad) begin
                m_int = di; m_frac = df;
            end else if (m_pend) begin
                m_int = m_sint; m_frac = m_sfrac;
            end
            m_pend = 0;
        end else begin
            if (e) begin
                m_done++;
                if (m_done == len) begin
                    e_os    = 1;
                    e_bit   = (m_phase == OS - 1);
                    m_phase = (m_phase + 1) % OS;
                    m_acc   = (m_acc + m_frac) % FMOD;
                    m_done  = 0;
                    if (m_pend) begin
                        m_int = m_sint; m_frac = m_sfrac; m_pend = 0;
                    end
                end
            end
            if (xfer && !bad) begin
                m_sint = di; m_sfrac = df; m_pend = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (os_tick === 1'b1) os_q.push_back(cyc_n);
        if (bit_tick === 1'b1) bit_q.push_back(cyc_n);
        chk_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        int r, n;

        // Reset state
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_outputs();
        arst_n = 1'b1;

        // Default divisor 651 + 1/16
        run(10420);
        chk("def_n_os", os_q.size(), 16);
        if (os_q.size() == 16) begin
            chk("def_first", os_q[0], 651);
            for (int i = 1; i < 15; i++) chk("def_gap", os_q[i] - os_q[i-1], 651);
            chk("def_gap16", os_q[15] - os_q[14], 652);
        end
        chk("def_n_bit", bit_q.size(), 1);
        if (bit_q.size() == 1) chk("def_bit", bit_q[0], 10417);

        // Program 4/0 through the handshake
        os_q.delete(); bit_q.delete();
        cyc(1, 0, 1, 4, 0);
        chk("ready_low_after_xfer", cfg_ready, 1'b0);
        run(900);
        n = bit_q.size();
        chk("int4_has_bits", n >= 2, 1'b1);
        if (n >= 2) chk("int4_bit_gap", bit_q[n-1] - bit_q[n-2], 64);
        n = os_q.size();
        if (n >= 2) chk("int4_os_gap", os_q[n-1] - os_q[n-2], 4);

        // 4.5 average via restart-coincident transfer
        os_q.delete();
        cyc(1, 1, 1, 4, 8);
        r = cyc_n;
        run(150);
        chk("frac_n_os", os_q.size() >= 32, 1'b1);
        if (os_q.size() >= 32) begin
            chk("frac_first", os_q[0] - r, 4);
            chk("frac_second", os_q[1] - os_q[0], 5);
            chk("frac_32", os_q[31] - r, 144);
        end

        // Rejected int=1, then int=2
        cyc(1, 0, 1, 1, 3);
        run(20);
        os_q.delete();
        cyc(1, 0, 1, 2, 0);
        run(30);
        n = os_q.size();
        if (n >= 2) chk("int2_gap", os_q[n-1] - os_q[n-2], 2);

        // Enable gap mid-interval with int=6
        os_q.delete();
        cyc(1, 1, 1, 6, 0);
        r = cyc_n;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        run(10);
        chk("en_gap_n", os_q.size() >= 1, 1'b1);
        if (os_q.size() >= 1) chk("en_gap_first", os_q[0] - r, 16);

        // Restart with int=8 offered while ticking at 4
        cyc(1, 1, 1, 4, 0);
        run(10);
        os_q.delete();
        cyc(1, 1, 1, 8, 0);
        r = cyc_n;
        chk("rs_phase0", os_phase, 0);
        run(20);
        if (os_q.size() >= 1) chk("rs_first8", os_q[0] - r, 8);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
                $urandom_range(0, 29) == 0, int'($urandom_range(0, 9)),
                int'($urandom_range(0, 15)));

        // Asynchronous reset mid-interval
        run(5);
        #2;
        arst_n = 1'b0;
        en = 1'b0; restart = 1'b0; cfg_valid = 1'b0;
        #1;
        m_reset();
        chk_outputs();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        cyc_n = 0;
        os_q.delete();
        run(655);
        chk("rst_n_os", os_q.size(), 1);
        if (os_q.size() >= 1) chk("rst_first", os_q[0], 651);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
